// File: rtl/dac_spi_tx.sv
// SPI transmitter for the quad current-command DAC: one 24-bit chip-select framed word per
// channel per sweep, built from a snapshot of cur_cmd taken when the sweep starts.
module dac_spi_tx #(
  parameter int         NUM_CHAN = 4,
  parameter int         CLK_DIV  = 2,
  parameter int         CS_GAP   = 4,
  parameter logic [3:0] CMD      = 4'b0011
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [16*NUM_CHAN-1:0]  cur_cmd,
  input  logic                    update,
  output logic                    busy,
  output logic                    done,
  output logic                    csel,
  output logic                    sclk,
  output logic                    mosi
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
  localparam logic [3:0]  LAST_CHAN = 4'(NUM_CHAN - 1);
  localparam logic [4:0]  LAST_BIT  = 5'd23;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        csel_q, csel_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        pending_q, pending_d;
  logic [3:0]  chan_q, chan_d;
  logic [15:0] div_q, div_d;
  logic [15:0] gap_q, gap_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] sh_q, sh_d;
  logic [15:0] snap_q [NUM_CHAN];
  logic [15:0] snap_d [NUM_CHAN];
  logic [15:0] next_word;

  logic start, half_end, fall, frame_end, gap_end, more_chan;

  function automatic logic [23:0] make_frame(input logic [3:0] ch, input logic [15:0] word);
    return {CMD, ch, word};
  endfunction

  assign start     = (state_q == S_IDLE) && (update || pending_q);
  assign half_end  = (state_q == S_SHIFT) && (div_q == DIV_LAST);
  assign fall      = half_end && sclk_q;
  assign frame_end = fall && (bit_q == LAST_BIT);
  assign gap_end   = (state_q == S_GAP) && (gap_q == GAP_LAST);
  assign more_chan = (chan_q != LAST_CHAN);

  // Control and pin registers: reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      csel_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      pending_q <= 1'b0;
      chan_q    <= '0;
      div_q     <= '0;
      gap_q     <= '0;
      bit_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      csel_q    <= csel_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      pending_q <= pending_d;
      chan_q    <= chan_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      bit_q     <= bit_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q   <= sh_d;
    snap_q <= snap_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (frame_end) state_d = S_GAP;
      S_GAP:   if (gap_end) state_d = more_chan ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d    = busy_q;
    done_d    = 1'b0;
    csel_d    = csel_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    pending_d = pending_q | update;
    chan_d    = chan_q;
    div_d     = div_q;
    gap_d     = gap_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    snap_d    = snap_q;
    next_word = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (chan_q + 4'd1 == 4'(i)) next_word = snap_q[i];
    end

    if (start) begin
      // Channel 0 frame comes straight from the inputs being captured this cycle.
      pending_d = 1'b0;
      busy_d    = 1'b1;
      chan_d    = '0;
      csel_d    = 1'b0;
      sclk_d    = 1'b0;
      div_d     = '0;
      bit_d     = '0;
      for (int i = 0; i < NUM_CHAN; i++) snap_d[i] = cur_cmd[16*i +: 16];
      sh_d      = make_frame(4'd0, cur_cmd[15:0]);
      mosi_d    = CMD[3];
    end else if (state_q == S_SHIFT) begin
      if (half_end) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        if (fall) begin
          if (frame_end) begin
            csel_d = 1'b1;
            mosi_d = 1'b0;
            gap_d  = '0;
          end else begin
            bit_d  = bit_q + 5'd1;
            sh_d   = {sh_q[22:0], 1'b0};
            mosi_d = sh_q[22];
          end
        end
      end else begin
        div_d = div_q + 16'd1;
      end
    end else if (state_q == S_GAP) begin
      if (gap_end) begin
        if (more_chan) begin
          chan_d = chan_q + 4'd1;
          csel_d = 1'b0;
          div_d  = '0;
          bit_d  = '0;
          sh_d   = make_frame(chan_q + 4'd1, next_word);
          mosi_d = CMD[3];
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        gap_d = gap_q + 16'd1;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign csel = csel_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (default and fastest parameter set) checked every cycle
// against a sweep-position model, plus serial-line frame decoding for the default instance.
module tb_dac_spi_tx;

  localparam logic [3:0] CMD = 4'b0011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset   = 1'b0;
  logic        update  = 1'b0;
  logic [63:0] cur_cmd = '0;
  logic busy0, done0, csel0, sclk0, mosi0;
  logic busy1, done1, csel1, sclk1, mosi1;

  dac_spi_tx #(.NUM_CHAN(4), .CLK_DIV(2), .CS_GAP(4), .CMD(CMD)) dut0 (
    .clk(clk), .reset(reset), .cur_cmd(cur_cmd), .update(update),
    .busy(busy0), .done(done0), .csel(csel0), .sclk(sclk0), .mosi(mosi0));

  dac_spi_tx #(.NUM_CHAN(1), .CLK_DIV(1), .CS_GAP(1), .CMD(CMD)) dut1 (
    .clk(clk), .reset(reset), .cur_cmd(cur_cmd[15:0]), .update(update),
    .busy(busy1), .done(done1), .csel(csel1), .sclk(sclk1), .mosi(mosi1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each instance is either idle or at cycle m_pos of a sweep.
  int p_n [2] = '{4, 1};
  int p_d [2] = '{2, 1};
  int p_g [2] = '{4, 1};
  bit m_busy [2];
  bit m_done [2];
  bit m_pend [2];
  int m_pos  [2];
  logic [15:0] m_snap [2][4];

  function automatic int frame_len(input int k);
    return 48 * p_d[k] + p_g[k];
  endfunction

  function automatic logic [23:0] frame_of(input int k, input int ch);
    return {CMD, 4'(ch), m_snap[k][ch]};
  endfunction

  task automatic model_step(input int k);
    m_done[k] = 1'b0;
    if (!reset) begin
      m_busy[k] = 1'b0;
      m_pend[k] = 1'b0;
    end else if (!m_busy[k]) begin
      if (update || m_pend[k]) begin
        m_busy[k] = 1'b1;
        m_pos[k]  = 0;
        m_pend[k] = 1'b0;
        for (int ch = 0; ch < p_n[k]; ch++) m_snap[k][ch] = cur_cmd[16*ch +: 16];
      end
    end else begin
      if (update) m_pend[k] = 1'b1;
      if (m_pos[k] == p_n[k] * frame_len(k) - 1) begin
        m_busy[k] = 1'b0;
        m_done[k] = 1'b1;
      end else begin
        m_pos[k]++;
      end
    end
  endtask

  // Expected {busy, done, csel, sclk, mosi} for the current cycle.
  task automatic expect_pins(input int k, output logic [4:0] e);
    int q, h;
    logic [23:0] f;
    e = {m_busy[k], m_done[k], 1'b1, 1'b0, 1'b0};
    if (m_busy[k]) begin
      q = m_pos[k] % frame_len(k);
      if (q < 48 * p_d[k]) begin
        h = q / p_d[k];
        f = frame_of(k, m_pos[k] / frame_len(k));
        e[2] = 1'b0;
        e[1] = h[0];
        e[0] = f[23 - h/2];
      end
    end
  endtask

  logic [4:0] prev_o [2] = '{5'b00100, 5'b00100};

  task automatic compare_all();
    logic [4:0] o [2];
    logic [4:0] e;
    o[0] = {busy0, done0, csel0, sclk0, mosi0};
    o[1] = {busy1, done1, csel1, sclk1, mosi1};
    for (int k = 0; k < 2; k++) begin
      expect_pins(k, e);
      chk($sformatf("pins%0d", k), 32'(o[k]), 32'(e));
      if (o[k][2]) chk($sformatf("sclk_idle%0d", k), 32'(o[k][1]), 32'd0);
      if (o[k][2] != prev_o[k][2]) chk($sformatf("csel_edge%0d", k), 32'(o[k][1]), 32'd0);
      if (o[k][1] != prev_o[k][1]) chk($sformatf("sclk_edge%0d", k), 32'(prev_o[k][2]), 32'd0);
      prev_o[k] = o[k];
    end
  endtask

  // Serial-line decoder for instance 0 plus activity counters.
  logic [23:0] dec_q [$];
  logic [23:0] dsh = '0;
  logic        dprev_sclk = 1'b0;
  logic        dprev_csel = 1'b1;
  int busy_cnt0, busy_cnt1, done_cnt0, done_cnt1;

  task automatic decode();
    if (!csel0 && sclk0 && !dprev_sclk) dsh = {dsh[22:0], mosi0};
    if (csel0 && !dprev_csel) dec_q.push_back(dsh);
    dprev_sclk = sclk0;
    dprev_csel = csel0;
    if (busy0) busy_cnt0++;
    if (busy1) busy_cnt1++;
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  endtask

  task automatic clear_stats();
    dec_q.delete();
    busy_cnt0 = 0; busy_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
    decode();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done0 && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 3000), 32'd1);
  endtask

  task automatic check_frames(input string tag, input int base, input logic [15:0] w [4]);
    for (int i = 0; i < 4; i++) begin
      if (base + i < dec_q.size())
        chk($sformatf("%s_f%0d", tag, i), 32'(dec_q[base+i]), 32'({CMD, 4'(i), w[i]}));
      else
        chk($sformatf("%s_missing%0d", tag, i), 32'd0, 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wa [4];
    logic [15:0] wb [4];
    logic [23:0] exp1 [4];
    int n;
    exp1 = '{24'h308000, 24'h311234, 24'h32FFFF, 24'h330000};

    run(3);
    chk("rst_pins0", 32'({busy0, done0, csel0, sclk0, mosi0}), 32'(5'b00100));
    chk("rst_pins1", 32'({busy1, done1, csel1, sclk1, mosi1}), 32'(5'b00100));
    reset = 1'b1;
    run(2);

    // Basic sweep with fixed values; instance 1 runs its single-channel sweep alongside.
    cur_cmd = 64'h0000_FFFF_1234_8000;
    clear_stats();
    pulse();
    wait_done("t1_done");
    run(20);
    chk("t1_busy", 32'(busy_cnt0), 32'd400);
    chk("t1_done_cnt", 32'(done_cnt0), 32'd1);
    chk("t1_nframes", 32'(dec_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < dec_q.size()) chk($sformatf("t1_f%0d", i), 32'(dec_q[i]), 32'(exp1[i]));
    chk("t6_busy1", 32'(busy_cnt1), 32'd49);
    chk("t6_done1", 32'(done_cnt1), 32'd1);

    // Input change mid-sweep must not reach the frames.
    clear_stats();
    for (int i = 0; i < 4; i++) wa[i] = 16'($urandom);
    if (wa[3] == 16'hABCD) wa[3] = 16'h1111;
    cur_cmd = {wa[3], wa[2], wa[1], wa[0]};
    pulse();
    run(9);
    cur_cmd[63:48] = 16'hABCD;
    wait_done("t2_done");
    run(50);
    chk("t2_done_cnt", 32'(done_cnt0), 32'd1);
    chk("t2_nframes", 32'(dec_q.size()), 32'd4);
    check_frames("t2", 0, wa);

    // Several updates while busy merge into one follow-on sweep with a fresh snapshot.
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      wa[i] = 16'($urandom);
      wb[i] = 16'($urandom);
    end
    cur_cmd = {wa[3], wa[2], wa[1], wa[0]};
    pulse();
    run(20);
    pulse();
    run(80);
    pulse();
    run(150);
    pulse();
    run(100);
    cur_cmd = {wb[3], wb[2], wb[1], wb[0]};
    wait_done("t3_done_a");
    tick();
    chk("t3_restart", 32'(busy0), 32'd1);
    wait_done("t3_done_b");
    run(50);
    chk("t3_done_cnt", 32'(done_cnt0), 32'd2);
    chk("t3_nframes", 32'(dec_q.size()), 32'd8);
    check_frames("t3a", 0, wa);
    check_frames("t3b", 4, wb);

    // Update on the done cycle.
    clear_stats();
    pulse();
    wait_done("t4_done_a");
    update = 1'b1;
    tick();
    update = 1'b0;
    n = 1;
    while (!done0 && n < 1000) begin
      tick();
      n++;
    end
    chk("t4_gap", 32'(n), 32'd401);
    run(20);
    chk("t4_done_cnt", 32'(done_cnt0), 32'd2);

    // Asynchronous reset in the middle of channel 1, bit 9, with sclk high and a pending sweep.
    clear_stats();
    pulse();
    n = 0;
    while (!(m_busy[0] && m_pos[0] == frame_len(0) + 4*9 + 3) && n < 1000) begin
      if (n == 50) update = 1'b1;
      tick();
      update = 1'b0;
      n++;
    end
    chk("t5_reach", 32'(n < 1000), 32'd1);
    chk("t5_sclk_high", 32'(sclk0), 32'd1);
    #2 reset = 1'b0;
    #1 chk("t5_async", 32'({csel0, sclk0, busy0, done0, mosi0}), 32'(5'b10000));
    run(3);
    reset = 1'b1;
    run(40);
    chk("t5_idle", 32'(busy0), 32'd0);
    chk("t5_no_done", 32'(done_cnt0), 32'd0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      update = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 15) == 0) cur_cmd = {$urandom, $urandom};
      tick();
      update = 1'b0;
    end
    run(500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
